// File: rtl/pool2d_window_scheduler.sv
// pool2d_window_scheduler
//
// Frame-buffered window sequencer for the 2-D pooling datapaths. A full input
// frame is captured one pixel per handshake in raster order, then every pooling
// window (KERNEL_HEIGHT x KERNEL_WIDTH pixels) is presented one per handshake in
// output-raster order.
//
// Ports:
//   clk              clock, rising-edge
//   rst              asynchronous active-low reset
//   data_in_0        input pixel
//   data_in_0_valid  input pixel valid
//   data_in_0_ready  high while capturing a frame
//   data_out_0       window, element m*KERNEL_WIDTH+n = pixel (orow*STRIDE+m, ocol*STRIDE+n)
//   data_out_0_valid window valid
//   data_out_0_ready downstream accepts the window
//   data_out_0_row   output row of the presented window
//   data_out_0_col   output column of the presented window
//   data_out_0_last  presented window is the final one of the frame
module pool2d_window_scheduler #(
   parameter int unsigned DATA_IN_0_PRECISION_0 = 8,
   parameter int unsigned DATA_IN_0_WIDTH       = 8,
   parameter int unsigned DATA_IN_0_HEIGHT      = 8,
   parameter int unsigned KERNEL_WIDTH          = 2,
   parameter int unsigned KERNEL_HEIGHT         = 2,
   parameter int unsigned STRIDE                = 2,
   localparam int unsigned OUT_W = (DATA_IN_0_WIDTH - KERNEL_WIDTH) / STRIDE + 1,
   localparam int unsigned OUT_H = (DATA_IN_0_HEIGHT - KERNEL_HEIGHT) / STRIDE + 1,
   localparam int unsigned RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
   localparam int unsigned CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0,
   input  logic                             data_in_0_valid,
   output logic                             data_in_0_ready,
   output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [KERNEL_HEIGHT*KERNEL_WIDTH],
   output logic                             data_out_0_valid,
   input  logic                             data_out_0_ready,
   output logic [RW-1:0]                    data_out_0_row,
   output logic [CW-1:0]                    data_out_0_col,
   output logic                             data_out_0_last
);

   localparam int unsigned NPIX = DATA_IN_0_HEIGHT * DATA_IN_0_WIDTH;
   localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;

   if (KERNEL_WIDTH > DATA_IN_0_WIDTH || KERNEL_HEIGHT > DATA_IN_0_HEIGHT || STRIDE == 0)
   begin : g_bad_params
      $error("pool2d_window_scheduler: kernel larger than frame or zero stride");
   end

   typedef enum logic [0:0] {StFill, StEmit} state_e;

   state_e                           state_q, state_d;
   logic [AW-1:0]                    wp_q, wp_d;
   logic [RW-1:0]                    orow_q, orow_d;
   logic [CW-1:0]                    ocol_q, ocol_d;
   logic                             in_hs;
   logic                             at_last;

   // Frame store; contents are only meaningful after a complete fill.
   logic [DATA_IN_0_PRECISION_0-1:0] mem [NPIX];

   assign at_last = (orow_q == RW'(OUT_H - 1)) && (ocol_q == CW'(OUT_W - 1));

   always_comb begin
      state_d          = state_q;
      wp_d             = wp_q;
      orow_d           = orow_q;
      ocol_d           = ocol_q;
      data_in_0_ready  = 1'b0;
      data_out_0_valid = 1'b0;
      in_hs            = 1'b0;
      unique case (state_q)
         StFill: begin
            data_in_0_ready = 1'b1;
            in_hs           = data_in_0_valid;
            if (data_in_0_valid) begin
               if (wp_q == AW'(NPIX - 1)) begin
                  wp_d    = '0;
                  orow_d  = '0;
                  ocol_d  = '0;
                  state_d = StEmit;
               end else begin
                  wp_d = wp_q + 1'b1;
               end
            end
         end
         StEmit: begin
            data_out_0_valid = 1'b1;
            if (data_out_0_ready) begin
               if (at_last) begin
                  orow_d  = '0;
                  ocol_d  = '0;
                  state_d = StFill;
               end else if (ocol_q == CW'(OUT_W - 1)) begin
                  ocol_d = '0;
                  orow_d = orow_q + 1'b1;
               end else begin
                  ocol_d = ocol_q + 1'b1;
               end
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StFill;
         wp_q    <= '0;
         orow_q  <= '0;
         ocol_q  <= '0;
      end else begin
         state_q <= state_d;
         wp_q    <= wp_d;
         orow_q  <= orow_d;
         ocol_q  <= ocol_d;
      end
   end

   always_ff @(posedge clk) begin
      if (in_hs) begin
         mem[wp_q] <= data_in_0;
      end
   end

   // Window read is combinational so a new window is visible the cycle the
   // counters move.
   for (genvar m = 0; m < KERNEL_HEIGHT; m++) begin : g_row
      for (genvar n = 0; n < KERNEL_WIDTH; n++) begin : g_col
         logic [AW-1:0] idx;
         assign idx = AW'((32'(orow_q) * STRIDE + 32'(m)) * DATA_IN_0_WIDTH
                          + 32'(ocol_q) * STRIDE + 32'(n));
         assign data_out_0[m*KERNEL_WIDTH+n] = data_out_0_valid ? mem[idx] : '0;
      end
   end

   assign data_out_0_row  = data_out_0_valid ? orow_q : '0;
   assign data_out_0_col  = data_out_0_valid ? ocol_q : '0;
   assign data_out_0_last = data_out_0_valid & at_last;

endmodule

// File: tb/tb_pool2d_window_scheduler.sv
module tb_pool2d_window_scheduler;

   localparam int IW = 8, IH = 8, KW = 2, KH = 2, S = 2;
   localparam int OW = (IW - KW) / S + 1;
   localparam int OH = (IH - KH) / S + 1;
   localparam int NW = OW * OH;
   localparam int NP = IW * IH;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic [7:0] dout [KH*KW];
   logic       dout_valid;
   logic       dout_ready;
   logic [1:0] dout_row;
   logic [1:0] dout_col;
   logic       dout_last;

   // Second instance: 4x4 frame, 3x3 kernel, stride 1.
   logic [7:0] b_din;
   logic       b_din_valid;
   logic       b_din_ready;
   logic [7:0] b_dout [9];
   logic       b_valid;
   logic       b_ready;
   logic [0:0] b_row;
   logic [0:0] b_col;
   logic       b_last;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   pool2d_window_scheduler dut (
      .clk              (clk),
      .rst              (rst),
      .data_in_0        (din),
      .data_in_0_valid  (din_valid),
      .data_in_0_ready  (din_ready),
      .data_out_0       (dout),
      .data_out_0_valid (dout_valid),
      .data_out_0_ready (dout_ready),
      .data_out_0_row   (dout_row),
      .data_out_0_col   (dout_col),
      .data_out_0_last  (dout_last)
   );

   pool2d_window_scheduler #(
      .DATA_IN_0_PRECISION_0 (8),
      .DATA_IN_0_WIDTH       (4),
      .DATA_IN_0_HEIGHT      (4),
      .KERNEL_WIDTH          (3),
      .KERNEL_HEIGHT         (3),
      .STRIDE                (1)
   ) dut_b (
      .clk              (clk),
      .rst              (rst),
      .data_in_0        (b_din),
      .data_in_0_valid  (b_din_valid),
      .data_in_0_ready  (b_din_ready),
      .data_out_0       (b_dout),
      .data_out_0_valid (b_valid),
      .data_out_0_ready (b_ready),
      .data_out_0_row   (b_row),
      .data_out_0_col   (b_col),
      .data_out_0_last  (b_last)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference frame: pixels in the order they were accepted.
   int frame [NP];
   // Windows captured during the most recent receive.
   int cap_e [NW][KH*KW];
   int cap_row [NW];
   int cap_col [NW];
   int cap_last [NW];
   int first_in_cyc;
   int last_out_cyc;

   typedef struct {
      int w;
      int row;
      int col;
      int e [4];
      int last;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pack_out();
      return {27'b0, dout[0], dout[1], dout[2], dout[3], dout_row, dout_col, dout_last};
   endfunction

   // Check the presented window against the reference model and record it.
   task automatic chk_win(input int w);
      int orow, ocol;
      orow = w / OW;
      ocol = w % OW;
      chk("out_valid", 64'(dout_valid), 64'd1);
      chk("out_row", 64'(dout_row), 64'(orow));
      chk("out_col", 64'(dout_col), 64'(ocol));
      chk("out_last", 64'(dout_last), 64'(w == NW - 1));
      for (int m = 0; m < KH; m++) begin
         for (int n = 0; n < KW; n++) begin
            chk("out_pixel", 64'(dout[m*KW+n]),
                64'(frame[(orow * S + m) * IW + ocol * S + n]));
            cap_e[w][m*KW+n] = int'(dout[m*KW+n]);
         end
      end
      cap_row[w]  = int'(dout_row);
      cap_col[w]  = int'(dout_col);
      cap_last[w] = int'(dout_last);
   endtask

   // kind 0: base+i, kind 1: 255-i, kind 2: random. gaps inserts random idle cycles.
   task automatic send_frame(input int kind, input int base, input bit gaps);
      int pix, k;
      for (int i = 0; i < NP; i++) begin
         if (gaps) begin
            din_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
               chk("in_ready_gap", 64'(din_ready), 64'd1);
            end
         end
         pix = (kind == 0) ? (base + i) & 255 : (kind == 1) ? 255 - i : int'($urandom_range(0, 255));
         din_valid = 1'b1;
         din       = 8'(pix);
         k = 0;
         while (din_ready !== 1'b1 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
         end
         if (k == 50) chk("in_ready_timeout", 64'(din_ready), 64'd1);
         frame[i] = pix;
         @(posedge clk);
         #1;
         if (i == 0) first_in_cyc = cyc;
      end
      din_valid = 1'b0;
   endtask

   // Collect one frame of windows. Optional stall at stall_at, reset at rst_at,
   // and a pending pixel held on the input throughout.
   task automatic recv_frame(input int stall_at, input int rst_at, input bit pend,
                             input int pend_pix);
      logic [63:0] snap;
      if (pend) begin
         din_valid = 1'b1;
         din       = 8'(pend_pix);
      end
      for (int w = 0; w < NW; w++) begin
         if (w == rst_at) begin
            rst = 1'b0;
            #1;
            chk("rst_out_valid", 64'(dout_valid), 64'd0);
            chk("rst_in_ready", 64'(din_ready), 64'd1);
            chk("rst_outputs", pack_out(), 64'd0);
            #2;
            rst = 1'b1;
            return;
         end
         chk_win(w);
         if (pend) chk("in_ready_emit", 64'(din_ready), 64'd0);
         if (w == stall_at) begin
            dout_ready = 1'b0;
            snap = pack_out();
            repeat (3) begin
               @(posedge clk);
               #1;
               chk("stall_stable", pack_out(), snap);
               chk("stall_valid", 64'(dout_valid), 64'd1);
            end
            dout_ready = 1'b1;
         end
         @(posedge clk);
         #1;
         if (w == NW - 1) last_out_cyc = cyc;
      end
      chk("turn_in_ready", 64'(din_ready), 64'd1);
      chk("turn_out_valid", 64'(dout_valid), 64'd0);
      chk("turn_outputs", pack_out(), 64'd0);
   endtask

   vec_t tbl [4];
   int   exp00 [9];
   int   exp11 [9];

   initial begin
      tbl[0] = '{w: 0,  row: 0, col: 0, e: '{0, 1, 8, 9},     last: 0};
      tbl[1] = '{w: 6,  row: 1, col: 2, e: '{20, 21, 28, 29}, last: 0};
      tbl[2] = '{w: 7,  row: 1, col: 3, e: '{22, 23, 30, 31}, last: 0};
      tbl[3] = '{w: 15, row: 3, col: 3, e: '{54, 55, 62, 63}, last: 1};
      exp00 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      exp11 = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

      rst         = 1'b0;
      din         = '0;
      din_valid   = 1'b0;
      dout_ready  = 1'b1;
      b_din       = '0;
      b_din_valid = 1'b0;
      b_ready     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", 64'(din_ready), 64'd1);
      chk("reset_out_valid", 64'(dout_valid), 64'd0);
      chk("reset_outputs", pack_out(), 64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_in_ready", 64'(din_ready), 64'd1);
      chk("post_reset_out_valid", 64'(dout_valid), 64'd0);

      // Ramp frame with a 3-cycle stall at window (1,2).
      send_frame(0, 0, 1'b0);
      recv_frame(6, -1, 1'b0, 0);
      for (int t = 0; t < 4; t++) begin
         chk("tbl_row", 64'(cap_row[tbl[t].w]), 64'(tbl[t].row));
         chk("tbl_col", 64'(cap_col[tbl[t].w]), 64'(tbl[t].col));
         chk("tbl_last", 64'(cap_last[tbl[t].w]), 64'(tbl[t].last));
         for (int e = 0; e < 4; e++) chk("tbl_pixel", 64'(cap_e[tbl[t].w][e]), 64'(tbl[t].e[e]));
      end

      // Random pixels with random input gaps.
      send_frame(2, 0, 1'b1);
      recv_frame(-1, -1, 1'b0, 0);

      // Reset during EMIT at window 5, then a fresh frame.
      send_frame(0, 0, 1'b0);
      recv_frame(-1, 5, 1'b0, 0);
      @(posedge clk);
      #1;
      chk("after_rst_in_ready", 64'(din_ready), 64'd1);
      send_frame(0, 100, 1'b0);
      recv_frame(-1, -1, 1'b0, 0);
      chk("fresh_w0_e0", 64'(cap_e[0][0]), 64'd100);
      chk("fresh_w0_e1", 64'(cap_e[0][1]), 64'd101);
      chk("fresh_w0_e2", 64'(cap_e[0][2]), 64'd108);
      chk("fresh_w0_e3", 64'(cap_e[0][3]), 64'd109);

      // Back-to-back frames; second frame's first pixel waits on the input.
      send_frame(0, 0, 1'b0);
      recv_frame(-1, -1, 1'b1, 255);
      send_frame(1, 0, 1'b0);
      chk("turnaround_cycles", 64'(first_in_cyc - last_out_cyc), 64'd1);
      recv_frame(-1, -1, 1'b0, 0);

      // 4x4 frame, 3x3 kernel, stride 1.
      for (int i = 0; i < 16; i++) begin
         b_din_valid = 1'b1;
         b_din       = 8'(i);
         @(posedge clk);
         #1;
      end
      b_din_valid = 1'b0;
      for (int w = 0; w < 4; w++) begin
         chk("b_valid", 64'(b_valid), 64'd1);
         chk("b_row", 64'(b_row), 64'(w / 2));
         chk("b_col", 64'(b_col), 64'(w % 2));
         chk("b_last", 64'(b_last), 64'(w == 3));
         for (int e = 0; e < 9; e++) begin
            chk("b_pixel", 64'(b_dout[e]), 64'(((w / 2) + e / 3) * 4 + (w % 2) + e % 3));
            if (w == 0) chk("b_win00", 64'(b_dout[e]), 64'(exp00[e]));
            if (w == 3) chk("b_win11", 64'(b_dout[e]), 64'(exp11[e]));
         end
         @(posedge clk);
         #1;
      end
      chk("b_done_ready", 64'(b_din_ready), 64'd1);
      chk("b_done_valid", 64'(b_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
